// File: rtl/sipo_pkg.sv
// Shared constants and helpers for the SIPO deserialiser.
// Parity build selected by SIPO_PARITY_EN; frame length derives from it.
package sipo_pkg;

`ifdef SIPO_PARITY_EN
  localparam bit PARITY_EN = 1'b1;
`else
  localparam bit PARITY_EN = 1'b0;
`endif

  // XOR over data plus parity bit equals this for a good frame
  localparam bit PARITY_EVEN = 1'b0;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++)
      if ((1 << r) < v) r++;
    return (r < 1) ? 1 : r;
  endfunction

  function automatic int frame_len(input int w);
    return w + (PARITY_EN ? 1 : 0);
  endfunction

endpackage

// File: rtl/sipo_shreg.sv
// WIDTH-bit shift register with direction select, enable and sync clear.
// Ports: clk, rst, clr, en, din in; nxt = value the register takes at the next edge.
module sipo_shreg
  import sipo_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic             din,
  output logic [WIDTH-1:0] nxt
);

  logic [WIDTH-1:0] sh;
  logic [WIDTH-1:0] shifted;

  if (MSB_FIRST != 0) begin : g_msb
    assign shifted = {sh[WIDTH-2:0], din};
  end else begin : g_lsb
    assign shifted = {din, sh[WIDTH-1:1]};
  end

  // Exposing next-state lets the top load a word on the last-bit edge
  always_comb begin
    nxt = sh;
    if (clr)
      nxt = '0;
    else if (en)
      nxt = shifted;
  end

  always_ff @(posedge clk) begin
    if (rst)
      sh <= '0;
    else
      sh <= nxt;
  end

endmodule

// File: rtl/sipo_deser.sv
// Serial-in/parallel-out deserialiser with valid/ready output and overrun flag.
// Ports: clk, rst, se_en, se_in, clr, pa_ready in; pa_out, pa_valid, overrun, parity_err out.
// Macro SIPO_PARITY_EN adds a trailing even-parity bit per frame.
module sipo_deser
  import sipo_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             se_en,
  input  logic             se_in,
  input  logic             clr,
  output logic [WIDTH-1:0] pa_out,
  output logic             pa_valid,
  input  logic             pa_ready,
  output logic             overrun,
  output logic             parity_err
);

  localparam int F     = frame_len(WIDTH);
  localparam int CNT_W = clog2(F);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(F - 1);

  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] word;
  logic             bit_ok;
  logic             last;
  logic             take;
  logic             load;
  logic             drop;
  logic             consume;

  assign bit_ok  = se_en && !clr;
  assign last    = bit_ok && (cnt == LAST);
  assign consume = pa_valid && pa_ready;
  assign load    = last && (!pa_valid || pa_ready);
  assign drop    = last && pa_valid && !pa_ready;

`ifdef SIPO_PARITY_EN
  // Parity bit is the last of the frame and never enters the data word
  assign take = bit_ok && !last;
`else
  assign take = bit_ok;
`endif

  sipo_shreg #(
    .WIDTH    (WIDTH),
    .MSB_FIRST(MSB_FIRST)
  ) u_shreg (
    .clk(clk),
    .rst(rst),
    .clr(clr),
    .en (take),
    .din(se_in),
    .nxt(word)
  );

  always_ff @(posedge clk) begin
    if (rst)
      cnt <= '0;
    else if (clr)
      cnt <= '0;
    else if (se_en)
      cnt <= last ? '0 : cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pa_out   <= '0;
      pa_valid <= 1'b0;
    end else if (load) begin
      pa_out   <= word;
      pa_valid <= 1'b1;
    end else if (consume) begin
      pa_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      overrun <= 1'b0;
    else if (clr)
      overrun <= 1'b0;
    else if (drop)
      overrun <= 1'b1;
  end

`ifdef SIPO_PARITY_EN
  logic perr;

  always_ff @(posedge clk) begin
    if (rst)
      perr <= 1'b0;
    else if (load)
      perr <= (^{word, se_in}) != PARITY_EVEN;
  end

  assign parity_err = perr;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_sipo_deser.sv
// Self-checking bench for sipo_deser: LSB-first and MSB-first instances
// driven in parallel against a bit-queue reference model.
module tb_sipo_deser;
  import sipo_pkg::*;

  localparam int W = 8;
  localparam int F = frame_len(W);

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         se_en = 1'b0;
  logic         se_in = 1'b0;
  logic         clr = 1'b0;
  logic         pa_ready = 1'b0;
  logic [W-1:0] o0, o1;
  logic         v0, v1, ov0, ov1, pe0, pe1;

  int passed = 0;
  int total  = 0;

  bit           q[$];
  logic [W-1:0] m_w0, m_w1;
  logic         m_v, m_ov, m_pe;

  always #5 clk = ~clk;

  sipo_deser #(.WIDTH(W), .MSB_FIRST(0)) d0 (
    .clk(clk), .rst(rst), .se_en(se_en), .se_in(se_in), .clr(clr),
    .pa_out(o0), .pa_valid(v0), .pa_ready(pa_ready),
    .overrun(ov0), .parity_err(pe0)
  );

  sipo_deser #(.WIDTH(W), .MSB_FIRST(1)) d1 (
    .clk(clk), .rst(rst), .se_en(se_en), .se_in(se_in), .clr(clr),
    .pa_out(o1), .pa_valid(v1), .pa_ready(pa_ready),
    .overrun(ov1), .parity_err(pe1)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Reference: collect frame bits, build words arithmetically when F arrive
  task automatic m_step(input logic r, input logic e, input logic d,
                        input logic c, input logic rdy);
    bit           done;
    bit           p;
    logic [W-1:0] a0, a1;
    done = 0;
    p    = 0;
    a0   = '0;
    a1   = '0;
    if (r) begin
      q.delete();
      m_w0 = '0; m_w1 = '0;
      m_v = 0; m_ov = 0; m_pe = 0;
      return;
    end
    if (c) begin
      q.delete();
    end else if (e) begin
      q.push_back(d);
      if (q.size() == F) begin
        for (int i = 0; i < W; i++) begin
          a0 = a0 | (W'(q[i]) << i);
          a1 = a1 | (W'(q[i]) << (W - 1 - i));
        end
        for (int i = 0; i < F; i++) p = p ^ q[i];
        q.delete();
        done = 1;
      end
    end
    if (done) begin
      if (!m_v || rdy) begin
        m_w0 = a0;
        m_w1 = a1;
        m_v  = 1;
        m_pe = (F > W) ? p : 1'b0;
      end else begin
        m_ov = 1;
      end
    end else if (m_v && rdy) begin
      m_v = 0;
    end
    if (c) m_ov = 0;
  endtask

  task automatic step(input logic e, input logic d, input logic c,
                      input logic rdy, input logic r = 1'b0);
    rst = r; se_en = e; se_in = d; clr = c; pa_ready = rdy;
    m_step(r, e, d, c, rdy);
    @(posedge clk);
    #1;
    chk("valid0", 32'(v0), 32'(m_v));
    chk("valid1", 32'(v1), 32'(m_v));
    chk("ovr0", 32'(ov0), 32'(m_ov));
    chk("ovr1", 32'(ov1), 32'(m_ov));
    chk("word0", 32'(o0), 32'(m_w0));
    chk("word1", 32'(o1), 32'(m_w1));
    chk("perr0", 32'(pe0), 32'(m_pe));
    chk("perr1", 32'(pe1), 32'(m_pe));
  endtask

  // Data bits LSB of w first, then parity bit when the frame has one
  task automatic send(input logic [W-1:0] w, input logic par,
                      input logic rdy_body, input logic rdy_last,
                      input bit gap = 0);
    logic b;
    for (int i = 0; i < F; i++) begin
      b = (i < W) ? w[i] : par;
      if (gap) step(1'b0, 1'($urandom), 1'b0, rdy_body);
      step(1'b1, b, 1'b0, (i == F - 1) ? rdy_last : rdy_body);
    end
  endtask

  initial begin
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("rst_word", 32'(o0), 32'h0);
    chk("rst_valid", 32'(v0), 32'h0);

    send(8'h55, ^8'h55, 1'b1, 1'b1);
    chk("t1_lsb", 32'(o0), 32'h55);
    chk("t2_msb", 32'(o1), 32'hAA);
    chk("t1_vld", 32'(v0), 32'h1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("t1_pulse", 32'(v0), 32'h0);

    send(8'h55, ^8'h55, 1'b1, 1'b1, 1);
    chk("t2_gap_msb", 32'(o1), 32'hAA);
    chk("t2_gap_vld", 32'(v1), 32'h1);
    step(1'b0, 1'b0, 1'b0, 1'b1);

    send(8'hA5, ^8'hA5, 1'b0, 1'b0);
    send(8'h3C, ^8'h3C, 1'b0, 1'b0);
    chk("t3_hold", 32'(o0), 32'hA5);
    chk("t3_ovr", 32'(ov0), 32'h1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("t3_drain", 32'(v0), 32'h0);
    chk("t3_sticky", 32'(ov0), 32'h1);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("t3_clr", 32'(ov0), 32'h0);

    send(8'h12, ^8'h12, 1'b0, 1'b0);
    send(8'h34, ^8'h34, 1'b0, 1'b1);
    chk("t4_word", 32'(o0), 32'h34);
    chk("t4_vld", 32'(v0), 32'h1);
    chk("t4_ovr", 32'(ov0), 32'h0);
    step(1'b0, 1'b0, 1'b0, 1'b1);

    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    send(8'hF0, ^8'hF0, 1'b1, 1'b1);
    chk("t5_abort", 32'(o0), 32'hF0);

    send(8'h77, ^8'h77, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("t5_rst_word", 32'(o0), 32'h0);
    chk("t5_rst_vld", 32'(v0), 32'h0);
    send(8'h9B, ^8'h9B, 1'b1, 1'b1);
    chk("t5_after", 32'(o0), 32'h9B);
    step(1'b0, 1'b0, 1'b0, 1'b1);

`ifdef SIPO_PARITY_EN
    send(8'h55, 1'b0, 1'b1, 1'b1);
    chk("t6_word_a", 32'(o0), 32'h55);
    chk("t6_pe_ok", 32'(pe0), 32'h0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    send(8'h55, 1'b1, 1'b1, 1'b1);
    chk("t6_word_b", 32'(o0), 32'h55);
    chk("t6_pe_bad", 32'(pe0), 32'h1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
`endif

    for (int i = 0; i < 600; i++)
      step(1'($urandom_range(0, 3) != 0), 1'($urandom),
           1'($urandom_range(0, 31) == 0), 1'($urandom_range(0, 2) != 0),
           1'($urandom_range(0, 199) == 0));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
